// File: rtl/edge_pulser_pkg.sv
// Shared definitions for the multi-channel edge pulser: edge-mode encodings
// and the pulse-counter width helper.
package edge_pulser_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Counter must hold PULSE_LEN itself; a length below 1 still gets one bit.
    function automatic int cnt_width(input int len);
        if (len < 1) begin
            return 1;
        end
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/edge_pulser_ch.sv
// One edge-pulser channel: optional synchroniser, history flop, mode-selected
// edge detect, pulse-stretch counter and sticky pending/overflow flags.
module edge_pulser_ch
    import edge_pulser_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1,
    parameter int RETRIGGER   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_in,
    input  logic [1:0] i_mode,
    input  logic       i_evt_clr,
    output logic       o_pulse,
    output logic       o_evt_pend,
    output logic       o_evt_ovf
);

    localparam int             CW     = cnt_width(PULSE_LEN);
    localparam logic [CW-1:0]  LEN_V  = CW'(PULSE_LEN);
    localparam bit             RETRIG = (RETRIGGER != 0);

    logic          w_s;
    logic          r_h;
    logic          w_rise;
    logic          w_fall;
    logic          w_det;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_pulse;
    logic          r_pend;
    logic          r_ovf;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = i_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= i_in;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        r_sync[k] <= r_sync[k-1];
                    end
                end
            end
            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // History resets low so a level already high at reset release reads as a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= 1'b0;
        end else begin
            r_h <= w_s;
        end
    end

    assign w_rise = w_s & ~r_h;
    assign w_fall = ~w_s & r_h;

    always_comb begin
        w_det = 1'b0;
        case (i_mode)
            MODE_RISE: w_det = w_rise;
            MODE_FALL: w_det = w_fall;
            MODE_BOTH: w_det = w_rise | w_fall;
            default:   w_det = 1'b0;
        endcase
    end

    // Without retrigger an edge inside a running pulse is simply ignored by the counter.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_det && ((r_cnt == '0) || RETRIG)) begin
            w_cnt_nxt = LEN_V;
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_pulse <= (w_cnt_nxt != '0);
        end
    end

    // A new edge beats a same-cycle clear for pending, but a clear always drops overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_pend <= w_det | (r_pend & ~i_evt_clr);
            r_ovf  <= ~i_evt_clr & (r_ovf | (w_det & r_pend));
        end
    end

    assign o_pulse    = r_pulse;
    assign o_evt_pend = r_pend;
    assign o_evt_ovf  = r_ovf;

endmodule

// File: rtl/edge_pulser.sv
// Multi-channel edge-to-pulse converter; each channel is fully independent
// with its own edge mode and sticky event flags.
module edge_pulser
    import edge_pulser_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1,
    parameter int RETRIGGER   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in,
    input  logic [2*WIDTH-1:0]   mode,
    input  logic [WIDTH-1:0]     evt_clr,
    output logic [WIDTH-1:0]     pulse,
    output logic [WIDTH-1:0]     evt_pend,
    output logic [WIDTH-1:0]     evt_ovf
);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            edge_pulser_ch #(
                .SYNC_STAGES (SYNC_STAGES),
                .PULSE_LEN   (PULSE_LEN),
                .RETRIGGER   (RETRIGGER)
            ) u_ch (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_in       (in[i]),
                .i_mode     (mode[2*i+1:2*i]),
                .i_evt_clr  (evt_clr[i]),
                .o_pulse    (pulse[i]),
                .o_evt_pend (evt_pend[i]),
                .o_evt_ovf  (evt_ovf[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_edge_pulser.sv
// Directed bench for edge_pulser: several parameterisations driven side by side
// with hand-computed expected pulse and flag sequences.
module tb_edge_pulser;
    import edge_pulser_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    // u0: SYNC=0 LEN=1 ; u1: SYNC=2 LEN=3 ; u2/u3: SYNC=0 LEN=4 retrig 1/0 ; u4: 4 channels SYNC=0 LEN=3
    logic       in0 = 1'b0, clr0 = 1'b0, p0, e0, o0;
    logic [1:0] mode0 = MODE_RISE;
    logic       in1 = 1'b1, clr1 = 1'b0, p1, e1, o1;
    logic [1:0] mode1 = MODE_FALL;
    logic       in23 = 1'b0, clr23 = 1'b0, p2, e2, o2, p3, e3, o3;
    logic [1:0] mode23 = MODE_BOTH;
    logic [3:0] in4 = 4'b0000, clr4 = 4'b0000, p4, e4, o4;
    logic [7:0] mode4 = {MODE_BOTH, MODE_FALL, MODE_RISE, MODE_OFF};

    edge_pulser #(.WIDTH(1), .SYNC_STAGES(0), .PULSE_LEN(1), .RETRIGGER(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in(in0), .mode(mode0), .evt_clr(clr0),
        .pulse(p0), .evt_pend(e0), .evt_ovf(o0));
    edge_pulser #(.WIDTH(1), .SYNC_STAGES(2), .PULSE_LEN(3), .RETRIGGER(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in(in1), .mode(mode1), .evt_clr(clr1),
        .pulse(p1), .evt_pend(e1), .evt_ovf(o1));
    edge_pulser #(.WIDTH(1), .SYNC_STAGES(0), .PULSE_LEN(4), .RETRIGGER(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in(in23), .mode(mode23), .evt_clr(clr23),
        .pulse(p2), .evt_pend(e2), .evt_ovf(o2));
    edge_pulser #(.WIDTH(1), .SYNC_STAGES(0), .PULSE_LEN(4), .RETRIGGER(0)) u3 (
        .clk(clk), .rst_n(rst_n), .in(in23), .mode(mode23), .evt_clr(clr23),
        .pulse(p3), .evt_pend(e3), .evt_ovf(o3));
    edge_pulser #(.WIDTH(4), .SYNC_STAGES(0), .PULSE_LEN(3), .RETRIGGER(1)) u4 (
        .clk(clk), .rst_n(rst_n), .in(in4), .mode(mode4), .evt_clr(clr4),
        .pulse(p4), .evt_pend(e4), .evt_ovf(o4));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_r;
        logic [7:0] exp_n;
        logic [5:0] exp_rst;

        // Reset state
        tick(); tick();
        check("rst_p0", {31'd0, p0}, 32'd0);
        check("rst_e0", {31'd0, e0}, 32'd0);
        check("rst_p4", {28'd0, p4}, 32'd0);
        check("rst_e4", {28'd0, e4}, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("u1_rise_in_fall_mode", {31'd0, p1}, 32'd0);

        // SYNC=0 LEN=1 rising edge
        in0 = 1'b1;
        tick();
        check("u0_pulse_hi", {31'd0, p0}, 32'd1);
        check("u0_pend_hi", {31'd0, e0}, 32'd1);
        tick();
        check("u0_pulse_lo", {31'd0, p0}, 32'd0);
        check("u0_pend_sticky", {31'd0, e0}, 32'd1);

        // SYNC=2 LEN=3 falling edge
        in1 = 1'b0;
        exp_r = 8'b0001_1100;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("u1_fall_t%0d", k + 1), {31'd0, p1}, {31'd0, exp_r[k]});
        end
        in1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("u1_rise_ignored_t%0d", k + 1), {31'd0, p1}, 32'd0);
        end

        // LEN=4 BOTH, edges two cycles apart, with and without retrigger
        exp_r = 8'b0011_1111;
        exp_n = 8'b0000_1111;
        in23 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) in23 = 1'b0;
            tick();
            check($sformatf("u2_retrig_t%0d", k), {31'd0, p2}, {31'd0, exp_r[k]});
            check($sformatf("u3_noretrig_t%0d", k), {31'd0, p3}, {31'd0, exp_n[k]});
        end
        check("u2_ovf_two_edges", {31'd0, o2}, 32'd1);
        check("u3_ovf_two_edges", {31'd0, o3}, 32'd1);
        clr23 = 1'b1;
        tick();
        clr23 = 1'b0;
        check("u2_pend_cleared", {31'd0, e2}, 32'd0);
        check("u2_ovf_cleared", {31'd0, o2}, 32'd0);
        in23 = 1'b1;
        tick();
        check("u2_pend_new", {31'd0, e2}, 32'd1);
        check("u2_ovf_single", {31'd0, o2}, 32'd0);
        in23 = 1'b0;
        clr23 = 1'b1;
        tick();
        clr23 = 1'b0;
        check("u2_pend_det_clr", {31'd0, e2}, 32'd1);
        check("u2_ovf_det_clr", {31'd0, o2}, 32'd0);

        // Four channels OFF/RISE/FALL/BOTH on a common toggle
        in4 = 4'b1111;
        tick(); check("u4_rise_t1", {28'd0, p4}, 32'hA);
        tick(); check("u4_rise_t2", {28'd0, p4}, 32'hA);
        tick(); check("u4_rise_t3", {28'd0, p4}, 32'hA);
        tick(); check("u4_rise_t4", {28'd0, p4}, 32'h0);
        in4 = 4'b0000;
        tick(); check("u4_fall_t1", {28'd0, p4}, 32'hC);
        mode4 = {MODE_OFF, MODE_OFF, MODE_OFF, MODE_OFF};
        tick(); check("u4_modesw_t2", {28'd0, p4}, 32'hC);
        tick(); check("u4_modesw_t3", {28'd0, p4}, 32'hC);
        tick(); check("u4_modesw_t4", {28'd0, p4}, 32'h0);
        check("u4_pend", {28'd0, e4}, 32'hE);
        check("u4_ovf", {28'd0, o4}, 32'h8);
        in4 = 4'b1111;
        tick(); tick();
        check("u4_off_no_pulse", {28'd0, p4}, 32'h0);

        // Reset mid-pulse, then release with inputs held high
        mode1 = MODE_RISE;
        in1 = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        in1 = 1'b1;
        tick(); tick(); tick();
        check("u1_pulse_before_rst", {31'd0, p1}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("u1_pulse_async_rst", {31'd0, p1}, 32'd0);
        check("u1_pend_async_rst", {31'd0, e1}, 32'd0);
        tick(); tick();
        check("u1_pulse_in_rst", {31'd0, p1}, 32'd0);
        check("u0_pulse_in_rst", {31'd0, p0}, 32'd0);
        rst_n = 1'b1;
        exp_rst = 6'b01_1100;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("u1_post_rst_t%0d", k + 1), {31'd0, p1}, {31'd0, exp_rst[k]});
            if (k == 0) check("u0_post_rst_t1", {31'd0, p0}, 32'd1);
            if (k == 1) check("u0_post_rst_t2", {31'd0, p0}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
